bsg_rotate_left_iter: RTL and testbench
=======================================

BSG_ROTATE_LEFT_ITER -- requirements
Module: bsg_rotate_left_iter

Interface
REQ-001 SHALL have parameter width_p, default 32, data width in bits; legal values are powers of two >= 2.
REQ-002 SHALL have derived localparam lg_width_lp = $clog2(width_p), the rotate-amount width and the iteration count.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n_i  input  1  reset is asynchronous and active-low.
REQ-005 data_i  input  width_p  operand to rotate.
REQ-006 rot_i  input  lg_width_lp  left-rotate amount.
REQ-007 v_i  input  1  data_i/rot_i valid.
REQ-008 ready_o  output  1  block can accept an operand.
REQ-009 o  output  width_p  rotated result.
REQ-010 v_o  output  1  o valid.
REQ-011 yumi_i  input  1  consumer takes o this cycle; legal only while v_o=1.

Function
REQ-012 SHALL compute o = data_i rotated left by rot_i, so that bit i of data_i appears at bit (i+rot_i) mod width_p.
REQ-013 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-014 ready_o SHALL be 1 only in IDLE; v_o SHALL be 1 only in DONE.
REQ-015 IDLE with v_i=1: on that edge, capture data_i into the working register, capture rot_i into the amount register, clear stage counter k to 0, and go to BUSY.
REQ-016 BUSY, each edge: if amount bit k=1, rotate the working register left by 2^k; k increments.
REQ-017 BUSY SHALL go to DONE on the edge where k = lg_width_lp-1 is processed, so BUSY lasts exactly lg_width_lp cycles.
REQ-018 Latency: if the operand is accepted in cycle t, v_o SHALL first be 1 in cycle t+1+lg_width_lp (cycle 6 for width_p=32 when t=0).
REQ-019 DONE: o and v_o SHALL hold stable until yumi_i=1; on that edge, go to IDLE. ready_o is 1 in the following cycle, not the same cycle.
REQ-020 v_i in BUSY or DONE SHALL be ignored, with no capture and no side effects.
REQ-021 yumi_i while v_o=0 SHALL be ignored.
REQ-022 o SHALL equal the working register in every state, and is meaningful only while v_o=1.
REQ-023 rot_i=0 without the macro SHALL still take the full lg_width_lp BUSY cycles, and o SHALL equal data_i.

Reset
REQ-024 reset_n_i=0 SHALL asynchronously force state=IDLE, k=0, working register=0, amount register=0; therefore o=0, v_o=0, ready_o=1.
REQ-025 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no output; the first operand after reset deassertion SHALL be processed normally.

Configuration
REQ-026 Macro BSG_ROTATE_LEFT_ZERO_BYPASS_EN defined: an operand accepted with rot_i=0 SHALL go directly from IDLE to DONE, so v_o=1 in cycle t+1 with o=data_i.
REQ-027 Macro undefined: all operands SHALL follow REQ-016..REQ-018 with no special case.

Structure
REQ-028 Package bsg_rotate_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE) and a helper function giving lg width from width_p.
REQ-029 The per-iteration conditional rotate-left-by-2^k SHALL be the sub-module bsg_rotate_left_stage (inputs: data, k, enable; output: rotated data; combinational).
REQ-030 Implementation SHALL contain only the three registers (state, working, amount) and the counter k.

Verification (width_p=32)
REQ-031 data_i=0x8000_0001, rot_i=1, accepted cycle 0 -> v_o=1 in cycle 6, o=0x0000_0003.
REQ-032 data_i=0x1234_5678, rot_i=4 -> o=0x2345_6781; hold yumi_i=0 for 10 cycles -> o and v_o stable, ready_o=0 throughout.
REQ-033 data_i=0xDEAD_BEEF, rot_i=16 -> o=0xBEEF_DEAD; data_i=0x0000_0001, rot_i=31 -> o=0x8000_0000.
REQ-034 v_i=1 with new data held during BUSY -> ignored; result is from the first operand only; the next operand is accepted in the cycle after the yumi_i cycle.
REQ-035 reset_n_i pulsed low in cycle 3 of BUSY -> v_o=0, o=0, ready_o=1 immediately; then data_i=0x0000_00F0, rot_i=8 -> o=0x0000_F000 at normal latency.
REQ-036 rot_i=0, data_i=0xA5A5_A5A5 -> o=0xA5A5_A5A5; v_o in cycle 1 with BSG_ROTATE_LEFT_ZERO_BYPASS_EN, cycle 6 without.

Source files
------------

// File: rtl/bsg_rotate_pkg.sv
// Shared FSM state type and width helper for the iterative left-rotator.
package bsg_rotate_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned lg_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bsg_rotate_left_stage.sv
// One iteration of the rotator: conditionally rotate left by 2^k_i.
import bsg_rotate_pkg::*;

module bsg_rotate_left_stage #(
    parameter int unsigned width_p = 32
) (
    input  logic [width_p-1:0]                  data_i,
    input  logic [lg_width(width_p)-1:0]        k_i,
    input  logic                                en_i,
    output logic [width_p-1:0]                  data_o
);

    localparam int unsigned lg_width_lp = lg_width(width_p);

    logic [lg_width_lp-1:0] w_sh;
    logic [2*width_p-1:0]   w_dbl;

    // Upper half of the doubled word shifted left is the left rotation; 2^k <= width_p/2 always.
    always_comb begin
        w_sh   = lg_width_lp'(1) << k_i;
        w_dbl  = {data_i, data_i} << w_sh;
        data_o = en_i ? w_dbl[2*width_p-1:width_p] : data_i;
    end

endmodule

// File: rtl/bsg_rotate_left_iter.sv
// Iterative left-rotator: one conditional rotate-by-2^k per BUSY cycle.
// Optional macro BSG_ROTATE_LEFT_ZERO_BYPASS_EN sends rot_i=0 straight to DONE.
import bsg_rotate_pkg::*;

module bsg_rotate_left_iter #(
    parameter int unsigned width_p = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [width_p-1:0]              data_i,
    input  logic [lg_width(width_p)-1:0]    rot_i,
    input  logic                            v_i,
    output logic                            ready_o,
    output logic [width_p-1:0]              o,
    output logic                            v_o,
    input  logic                            yumi_i
);

    localparam int unsigned lg_width_lp = lg_width(width_p);
    localparam logic [lg_width_lp-1:0] K_LAST = lg_width_lp'(lg_width_lp - 1);

    state_e                 r_state;
    logic [width_p-1:0]     r_work;
    logic [lg_width_lp-1:0] r_amt;
    logic [lg_width_lp-1:0] r_k;

    logic [width_p-1:0]     w_stage;
    logic                   w_en;

    assign w_en = r_amt[r_k];

    bsg_rotate_left_stage #(
        .width_p (width_p)
    ) u_stage (
        .data_i (r_work),
        .k_i    (r_k),
        .en_i   (w_en),
        .data_o (w_stage)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_amt   <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (v_i) begin
                        r_work <= data_i;
                        r_amt  <= rot_i;
                        r_k    <= '0;
`ifdef BSG_ROTATE_LEFT_ZERO_BYPASS_EN
                        r_state <= (rot_i == '0) ? DONE : BUSY;
`else
                        r_state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    r_work <= w_stage;
                    r_k    <= r_k + lg_width_lp'(1);
                    if (r_k == K_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o = (r_state == IDLE);
    assign v_o     = (r_state == DONE);
    assign o       = r_work;

endmodule

// File: tb/tb_bsg_rotate_left_iter.sv
// Directed bench for bsg_rotate_left_iter at width_p=32 (honours BSG_ROTATE_LEFT_ZERO_BYPASS_EN).
module tb_bsg_rotate_left_iter;

    localparam int W  = 32;
    localparam int LG = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  data = '0;
    logic [LG-1:0] rot = '0;
    logic          v_i = 1'b0;
    logic          yumi = 1'b0;
    logic          ready;
    logic [W-1:0]  o;
    logic          vo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic [LG-1:0] r;
        logic [W-1:0]  e;
    } vec_t;

    vec_t vecs[7];

    bsg_rotate_left_iter #(.width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .data_i    (data),
        .rot_i     (rot),
        .v_i       (v_i),
        .ready_o   (ready),
        .o         (o),
        .v_o       (vo),
        .yumi_i    (yumi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [LG-1:0] r);
`ifdef BSG_ROTATE_LEFT_ZERO_BYPASS_EN
        return (r == '0) ? 1 : LG + 1;
`else
        return LG + 1;
`endif
    endfunction

    // Called at the negedge of the cycle after acceptance (cycle t+1).
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (vo !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume(input string name);
        yumi = 1'b1;
        check({name, "_ready_in_yumi_cycle"}, 32'(ready), 32'd0);
        @(negedge clk);
        yumi = 1'b0;
        check({name, "_ready_after_yumi"}, 32'(ready), 32'd1);
        check({name, "_vo_after_yumi"}, 32'(vo), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] d, input logic [LG-1:0] r,
                          input logic [W-1:0] e);
        int cyc;
        @(negedge clk);
        check({name, "_ready_idle"}, 32'(ready), 32'd1);
        data = d;
        rot  = r;
        v_i  = 1'b1;
        @(negedge clk);
        v_i  = 1'b0;
        data = ~d;
        rot  = ~r;
        wait_valid(cyc);
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat(r)));
        check({name, "_o"}, o, e);
        consume(name);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{32'h8000_0001, 5'd1,  32'h0000_0003};
        vecs[1] = '{32'h1234_5678, 5'd4,  32'h2345_6781};
        vecs[2] = '{32'hDEAD_BEEF, 5'd16, 32'hBEEF_DEAD};
        vecs[3] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[4] = '{32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[5] = '{32'h0000_00F0, 5'd8,  32'h0000_F000};
        vecs[6] = '{32'h0000_0001, 5'd5,  32'h0000_0020};

        #12;
        check("reset_o", o, 32'd0);
        check("reset_vo", 32'(vo), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // yumi with no valid output must not disturb IDLE
        @(negedge clk);
        yumi = 1'b1;
        @(negedge clk);
        yumi = 1'b0;
        check("stray_yumi_ready", 32'(ready), 32'd1);
        check("stray_yumi_vo", 32'(vo), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].r, vecs[i].e);
        end

        // Output held while consumer stalls
        @(negedge clk);
        data = 32'h1234_5678; rot = 5'd4; v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        wait_valid(cyc);
        check("hold_latency", 32'(cyc), 32'd6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_o", o, 32'h2345_6781);
            check("hold_vo", 32'(vo), 32'd1);
            check("hold_ready", 32'(ready), 32'd0);
        end
        consume("hold");

        // v_i held with new data while busy is ignored; accepted right after yumi
        @(negedge clk);
        data = 32'h0000_0003; rot = 5'd2; v_i = 1'b1;
        @(negedge clk);
        data = 32'hFFFF_0000; rot = 5'd4;
        check("ign_ready_busy", 32'(ready), 32'd0);
        wait_valid(cyc);
        check("ign_latency", 32'(cyc), 32'd6);
        check("ign_o_first", o, 32'h0000_000C);
        yumi = 1'b1;
        @(negedge clk);
        yumi = 1'b0;
        check("ign_ready_next", 32'(ready), 32'd1);
        @(negedge clk);
        v_i = 1'b0;
        wait_valid(cyc);
        check("ign_latency2", 32'(cyc), 32'd6);
        check("ign_o_second", o, 32'hFFF0_000F);
        consume("ign");

        // Asynchronous reset in the third BUSY cycle aborts the operation
        @(negedge clk);
        data = 32'h1234_5678; rot = 5'd3; v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_vo", 32'(vo), 32'd0);
        check("rst_mid_o", o, 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post_rst", 32'h0000_00F0, 5'd8, 32'h0000_F000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
